// File: rtl/gate_truth_checker.sv
// Clocked stimulus and checker for a two-input basic-gate block. Steps {a,b} through
// 00, 01, 10, 11, holds each for HOLD cycles, and compares the six gate outputs against
// the expected truth table on the last hold cycle of each combination.
module gate_truth_checker #(
  parameter int unsigned HOLD = 10,
  parameter logic [23:0] EXP  = 24'hC5A68D
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] obs,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_mask,
  output logic [2:0] err_cnt
);

  // A one-cycle hold still needs a one-bit counter that only ever reads zero.
  localparam int unsigned CntW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(HOLD - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      combo_q, combo_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [3:0]      err_mask_q, err_mask_d;
  logic [2:0]      err_cnt_q, err_cnt_d;

  logic [5:0]      exp_slice;
  logic            mismatch;

  // Select the expected output vector for the combination currently driven.
  always_comb begin
    exp_slice = EXP[5:0];
    unique case (combo_q)
      2'd0: exp_slice = EXP[5:0];
      2'd1: exp_slice = EXP[11:6];
      2'd2: exp_slice = EXP[17:12];
      2'd3: exp_slice = EXP[23:18];
      default: exp_slice = EXP[5:0];
    endcase
  end

  // Exact compare; written so an unknown obs falls through as a mismatch.
  always_comb begin
    mismatch = 1'b1;
    if (obs == exp_slice) begin
      mismatch = 1'b0;
    end
  end

  // Next-state logic for the run sequencer and result registers.
  always_comb begin
    state_d    = state_q;
    combo_d    = combo_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_mask_d = err_mask_q;
    err_cnt_d  = err_cnt_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StRun;
          combo_d    = 2'd0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          err_mask_d = 4'd0;
          err_cnt_d  = 3'd0;
        end
      end
      StRun: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (mismatch) begin
            err_mask_d[combo_q] = 1'b1;
            err_cnt_d           = err_cnt_q + 3'd1;
          end
          if (combo_q == 2'd3) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            // Fold in the final compare made on this same edge.
            pass_d  = (err_cnt_q == 3'd0) && !mismatch;
          end else begin
            combo_d = combo_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      combo_q    <= 2'd0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_mask_q <= 4'd0;
      err_cnt_q  <= 3'd0;
    end else begin
      state_q    <= state_d;
      combo_q    <= combo_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_mask_q <= err_mask_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // The combination register is the stimulus itself, so a/b are registered outputs.
  assign a        = combo_q[1];
  assign b        = combo_q[0];
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_mask = err_mask_q;
  assign err_cnt  = err_cnt_q;

endmodule
